// File: rtl/seq_controller_if.sv
// seq_controller_if: control bus between the sequence controller and its
// datapath. The "master" modport is the controller side (drives the datapath
// controls); the "slave" modport is the datapath side (supplies opcode/flags).
// OPC_W must match the OPC_W of the seq_controller this bus is attached to.
interface seq_controller_if #(
    parameter int unsigned OPC_W = 3
);
    // Datapath to controller
    logic [OPC_W-1:0] opcode;
    logic             is_zero;
    logic             mem_ready;
    logic             resume;

    // Controller to datapath
    logic             inc_pc;
    logic             ld_pc;
    logic             sel;
    logic             rd;
    logic             wr;
    logic             ld_ir;
    logic             ld_ac;
    logic             data_e;
    logic             halted;
    logic             mem_err;
    logic [3:0]       phase;

    modport master (
        input  opcode, is_zero, mem_ready, resume,
        output inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e,
               halted, mem_err, phase
    );

    modport slave (
        output opcode, is_zero, mem_ready, resume,
        input  inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e,
               halted, mem_err, phase
    );
endinterface

// File: rtl/seq_controller.sv
// seq_controller: eight-phase instruction sequencer with memory-handshake
// stalls, a per-access stall timeout and a HALT state.
// Optional build macro CTRL_STEP_EN: when defined, every completed STORE
// phase drops into HALT so each resume pulse runs exactly one instruction.
module seq_controller #(
    parameter int unsigned OPC_W    = 3,
    parameter int unsigned OP_HLT   = 0,
    parameter int unsigned OP_SKZ   = 1,
    parameter int unsigned OP_ADD   = 2,
    parameter int unsigned OP_AND   = 3,
    parameter int unsigned OP_XOR   = 4,
    parameter int unsigned OP_LDA   = 5,
    parameter int unsigned OP_STO   = 6,
    parameter int unsigned OP_JMP   = 7,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    seq_controller_if.master bus
);

    // Phase encodings, also presented on bus.phase
    localparam logic [3:0] S_INST_ADDR  = 4'd0;
    localparam logic [3:0] S_INST_FETCH = 4'd1;
    localparam logic [3:0] S_INST_LOAD  = 4'd2;
    localparam logic [3:0] S_IDLE       = 4'd3;
    localparam logic [3:0] S_OP_ADDR    = 4'd4;
    localparam logic [3:0] S_OP_FETCH   = 4'd5;
    localparam logic [3:0] S_ALU_OP     = 4'd6;
    localparam logic [3:0] S_STORE      = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;

    localparam logic [7:0] STALL_LIMIT  = 8'(WAIT_MAX);

    logic [3:0]       state_q, state_d;
    logic [7:0]       stall_q, stall_d;
    logic             err_q, err_d;

    logic [OPC_W-1:0] opc;
    logic             op_hlt, op_skz, op_add, op_and;
    logic             op_xor, op_lda, op_sto, op_jmp;
    logic             aluop;
    logic             mem_state;
    logic             store_done_halt;

    assign opc    = bus.opcode;
    assign op_hlt = (opc == OPC_W'(OP_HLT));
    assign op_skz = (opc == OPC_W'(OP_SKZ));
    assign op_add = (opc == OPC_W'(OP_ADD));
    assign op_and = (opc == OPC_W'(OP_AND));
    assign op_xor = (opc == OPC_W'(OP_XOR));
    assign op_lda = (opc == OPC_W'(OP_LDA));
    assign op_sto = (opc == OPC_W'(OP_STO));
    assign op_jmp = (opc == OPC_W'(OP_JMP));
    assign aluop  = op_add | op_and | op_xor | op_lda;

`ifdef CTRL_STEP_EN
    assign store_done_halt = 1'b1;
`else
    assign store_done_halt = 1'b0;
`endif

    // State, stall counter and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INST_ADDR;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Next-state: nominal phase sequence, then the memory-stall override.
    // stall_d defaults to zero, so the counter is clear on entry to every
    // state and only accumulates while a memory state is being held.
    always_comb begin
        state_d   = state_q;
        stall_d   = '0;
        err_d     = err_q;
        mem_state = 1'b0;

        case (state_q)
            S_INST_ADDR:  state_d = S_INST_FETCH;
            S_INST_FETCH: begin
                mem_state = 1'b1;
                state_d   = S_INST_LOAD;
            end
            S_INST_LOAD:  state_d = S_IDLE;
            S_IDLE:       state_d = S_OP_ADDR;
            S_OP_ADDR:    state_d = op_hlt ? S_HALT : S_OP_FETCH;
            S_OP_FETCH: begin
                mem_state = aluop;
                state_d   = S_ALU_OP;
            end
            S_ALU_OP:     state_d = S_STORE;
            S_STORE: begin
                mem_state = op_sto;
                state_d   = store_done_halt ? S_HALT : S_INST_ADDR;
            end
            S_HALT: begin
                if (bus.resume && !err_q) begin
                    state_d = S_INST_ADDR;
                end
            end
            default:      state_d = S_INST_ADDR;
        endcase

        if (mem_state && !bus.mem_ready) begin
            if (stall_q == STALL_LIMIT) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                state_d = state_q;
                stall_d = stall_q + 8'd1;
            end
        end
    end

    // Datapath controls decoded from the current phase and opcode
    always_comb begin
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.data_e = 1'b0;

        case (state_q)
            S_INST_ADDR: begin
                bus.sel = 1'b1;
            end
            S_INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
            end
            S_OP_ADDR: begin
                bus.inc_pc = 1'b1;
            end
            S_OP_FETCH: begin
                bus.rd = aluop;
            end
            S_ALU_OP: begin
                bus.rd     = aluop;
                bus.inc_pc = op_skz & bus.is_zero;
                bus.ld_pc  = op_jmp;
                bus.data_e = op_sto;
            end
            S_STORE: begin
                bus.rd     = aluop;
                bus.ld_ac  = aluop;
                bus.inc_pc = op_jmp;
                bus.ld_pc  = op_jmp;
                bus.wr     = op_sto;
                bus.data_e = op_sto;
            end
            default: begin
                // HALT and unused encodings drive no datapath controls
            end
        endcase
    end

    // Status outputs
    always_comb begin
        bus.phase   = state_q;
        bus.halted  = (state_q == S_HALT);
        bus.mem_err = err_q;
    end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed scoreboard bench for seq_controller.
// Honors CTRL_STEP_EN: when defined, each completed instruction is expected
// to land in HALT and is released with a resume pulse.
module tb_seq_controller;

    // Expected control vector order:
    // {inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e, halted, mem_err}
    localparam logic [9:0] C_IADDR    = 10'b0010000000;
    localparam logic [9:0] C_IFETCH   = 10'b0011000000;
    localparam logic [9:0] C_ILOAD    = 10'b0011010000;
    localparam logic [9:0] C_OPADDR   = 10'b1000000000;
    localparam logic [9:0] C_NONE     = 10'b0000000000;
    localparam logic [9:0] C_RD       = 10'b0001000000;
    localparam logic [9:0] C_ST_ALU   = 10'b0001001000;
    localparam logic [9:0] C_ALU_STO  = 10'b0000000100;
    localparam logic [9:0] C_ST_STO   = 10'b0000100100;
    localparam logic [9:0] C_INC      = 10'b1000000000;
    localparam logic [9:0] C_LDPC     = 10'b0100000000;
    localparam logic [9:0] C_INC_LDPC = 10'b1100000000;
    localparam logic [9:0] C_HALT     = 10'b0000000010;
    localparam logic [9:0] C_HALT_ERR = 10'b0000000011;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    seq_controller_if #(.OPC_W(3)) bus ();

    seq_controller #(
        .OPC_W   (3),
        .WAIT_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the expectation for the current cycle, compare at mid-cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] ph, input logic [9:0] ctl);
        exp_t        e;
        logic [13:0] obs;
        e.tag = tag;
        e.v   = {ph, ctl};
        sb.push_back(e);
        @(negedge clk);
        obs = {bus.phase, bus.inc_pc, bus.ld_pc, bus.sel, bus.rd, bus.wr,
               bus.ld_ir, bus.ld_ac, bus.data_e, bus.halted, bus.mem_err};
        e = sb.pop_front();
        checks++;
        assert (obs === e.v)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic after_store();
`ifdef CTRL_STEP_EN
        cyc("step_halt", 4'd8, C_HALT);
        bus.resume = 1'b1;
        cyc("step_resume", 4'd8, C_HALT);
        bus.resume = 1'b0;
`endif
    endtask

    task automatic front(input string tag);
        cyc({tag, "_p0"}, 4'd0, C_IADDR);
        cyc({tag, "_p1"}, 4'd1, C_IFETCH);
        cyc({tag, "_p2"}, 4'd2, C_ILOAD);
        cyc({tag, "_p3"}, 4'd3, C_ILOAD);
        cyc({tag, "_p4"}, 4'd4, C_OPADDR);
    endtask

    task automatic normal(input string tag, input logic [2:0] opc, input logic iz,
                          input logic [9:0] e5, input logic [9:0] e6, input logic [9:0] e7);
        bus.opcode  = opc;
        bus.is_zero = iz;
        front(tag);
        cyc({tag, "_p5"}, 4'd5, e5);
        cyc({tag, "_p6"}, 4'd6, e6);
        cyc({tag, "_p7"}, 4'd7, e7);
        after_store();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.opcode    = LDA;
        bus.is_zero   = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;

        // Reset state
        cyc("rst_a", 4'd0, C_IADDR);
        cyc("rst_b", 4'd0, C_IADDR);
        rst = 1'b1;

        // Plain instructions, no stalls
        normal("lda1", LDA, 1'b0, C_RD, C_RD, C_ST_ALU);
        normal("lda2", LDA, 1'b0, C_RD, C_RD, C_ST_ALU);
        normal("xor",  XOR, 1'b0, C_RD, C_RD, C_ST_ALU);
        normal("skz1", SKZ, 1'b1, C_NONE, C_INC, C_NONE);
        normal("skz0", SKZ, 1'b0, C_NONE, C_NONE, C_NONE);
        normal("jmp",  JMP, 1'b0, C_NONE, C_LDPC, C_INC_LDPC);

        // ADD: stray resume ignored, two stalls in OP_FETCH
        bus.opcode = ADD;
        cyc("add_p0", 4'd0, C_IADDR);
        cyc("add_p1", 4'd1, C_IFETCH);
        bus.resume = 1'b1;
        cyc("add_p2_resume", 4'd2, C_ILOAD);
        bus.resume = 1'b0;
        cyc("add_p3", 4'd3, C_ILOAD);
        cyc("add_p4", 4'd4, C_OPADDR);
        bus.mem_ready = 1'b0;
        cyc("add_p5_st0", 4'd5, C_RD);
        cyc("add_p5_st1", 4'd5, C_RD);
        bus.mem_ready = 1'b1;
        cyc("add_p5_go", 4'd5, C_RD);
        cyc("add_p6", 4'd6, C_RD);
        cyc("add_p7", 4'd7, C_ST_ALU);
        after_store();

        // LDA: mem_ready low in non-memory phases does not hold them
        bus.opcode = LDA;
        front("ldanm");
        cyc("ldanm_p5", 4'd5, C_RD);
        bus.mem_ready = 1'b0;
        cyc("ldanm_p6", 4'd6, C_RD);
        cyc("ldanm_p7", 4'd7, C_ST_ALU);
        bus.mem_ready = 1'b1;
        after_store();

        // STO: STORE held three extra cycles
        bus.opcode = STO;
        front("sto");
        cyc("sto_p5", 4'd5, C_NONE);
        cyc("sto_p6", 4'd6, C_ALU_STO);
        bus.mem_ready = 1'b0;
        cyc("sto_p7_st0", 4'd7, C_ST_STO);
        cyc("sto_p7_st1", 4'd7, C_ST_STO);
        cyc("sto_p7_st2", 4'd7, C_ST_STO);
        bus.mem_ready = 1'b1;
        cyc("sto_p7_go", 4'd7, C_ST_STO);
        after_store();

        // mem_ready arrives exactly at the stall limit: no error
        bus.opcode = LDA;
        cyc("lim_p0", 4'd0, C_IADDR);
        bus.mem_ready = 1'b0;
        cyc("lim_p1_st0", 4'd1, C_IFETCH);
        cyc("lim_p1_st1", 4'd1, C_IFETCH);
        cyc("lim_p1_st2", 4'd1, C_IFETCH);
        cyc("lim_p1_st3", 4'd1, C_IFETCH);
        bus.mem_ready = 1'b1;
        cyc("lim_p1_go", 4'd1, C_IFETCH);
        cyc("lim_p2", 4'd2, C_ILOAD);
        cyc("lim_p3", 4'd3, C_ILOAD);
        cyc("lim_p4", 4'd4, C_OPADDR);
        cyc("lim_p5", 4'd5, C_RD);
        cyc("lim_p6", 4'd6, C_RD);
        cyc("lim_p7", 4'd7, C_ST_ALU);
        after_store();

        // HLT: halt after OP_ADDR, resume returns to phase 0
        bus.opcode = HLT;
        front("hlt");
        cyc("hlt_h0", 4'd8, C_HALT);
        cyc("hlt_h1", 4'd8, C_HALT);
        bus.resume = 1'b1;
        cyc("hlt_h_resume", 4'd8, C_HALT);
        bus.resume = 1'b0;
        normal("lda_after_hlt", LDA, 1'b0, C_RD, C_RD, C_ST_ALU);

        // Asynchronous reset in the middle of a stall
        cyc("mid_p0", 4'd0, C_IADDR);
        bus.mem_ready = 1'b0;
        cyc("mid_p1_st0", 4'd1, C_IFETCH);
        cyc("mid_p1_st1", 4'd1, C_IFETCH);
        rst = 1'b0;
        cyc("mid_rst", 4'd0, C_IADDR);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        normal("lda_after_mid", LDA, 1'b0, C_RD, C_RD, C_ST_ALU);

        // Timeout in INST_FETCH: HALT with sticky error, resume ignored
        cyc("to_p0", 4'd0, C_IADDR);
        bus.mem_ready = 1'b0;
        cyc("to_p1_st0", 4'd1, C_IFETCH);
        cyc("to_p1_st1", 4'd1, C_IFETCH);
        cyc("to_p1_st2", 4'd1, C_IFETCH);
        cyc("to_p1_st3", 4'd1, C_IFETCH);
        cyc("to_p1_st4", 4'd1, C_IFETCH);
        cyc("to_halt", 4'd8, C_HALT_ERR);
        bus.resume = 1'b1;
        cyc("to_resume", 4'd8, C_HALT_ERR);
        bus.resume = 1'b0;
        cyc("to_stays", 4'd8, C_HALT_ERR);
        rst = 1'b0;
        cyc("to_rst", 4'd0, C_IADDR);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        normal("lda_after_to", LDA, 1'b0, C_RD, C_RD, C_ST_ALU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
